// File: rtl/nubus_master_retry.sv
// NuBus master transaction sequencer: launch, bus timeout timer, TRY_AGAIN_LATER retry with fixed backoff.
// State advances on the rising edge of nub_clkn (NuBus clock falling edge); NUBUS_RETRY_STATS_EN adds a retry counter.
module nubus_master_retry #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETRY_MAX      = 7,
  parameter int BACKOFF_CYCLES = 4
) (
  input  logic       nub_clkn,
  input  logic       nub_resetn,
  input  logic       cpu_req,
  output logic       cpu_ack_o,
  output logic [1:0] cpu_status_o,
  output logic       busy_o,
  output logic       mst_start_o,
  input  logic       mst_ack,
  input  logic [1:0] nub_tmn,
  output logic       mst_timeout_o,
  output logic       mst_tryagain_o
`ifdef NUBUS_RETRY_STATS_EN
  ,
  input  logic       stat_clr,
  output logic [7:0] stat_retries_o
`endif
);

  localparam logic [1:0] TMN_COMPLETE        = 2'd0;
  localparam logic [1:0] TMN_ERROR           = 2'd1;
  localparam logic [1:0] TMN_TIMEOUT_ERROR   = 2'd2;
  localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int BW = $clog2(BACKOFF_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(RETRY_MAX);
  localparam logic [BW-1:0] BACKOFF_LAST = BW'(BACKOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_BACKOFF,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_retry;
  logic [BW-1:0] r_backoff;
  logic          r_start;
  logic          r_cpu_ack;
  logic          r_timeout;
  logic          r_tryagain;
  logic [1:0]    r_status;
  logic          w_tal_ack;

  assign w_tal_ack = mst_ack && (nub_tmn == TMN_TRY_AGAIN_LATER);

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_retry    <= '0;
      r_backoff  <= '0;
      r_start    <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_timeout  <= 1'b0;
      r_tryagain <= 1'b0;
      r_status   <= TMN_COMPLETE;
    end else begin
      r_start    <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_timeout  <= 1'b0;
      r_tryagain <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_retry <= '0;
            r_timer <= '0;
            r_start <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // The launch clock is clock 0 of the timeout window, so WAIT begins at 1.
          r_timer <= TW'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_tal_ack) begin
            r_tryagain <= 1'b1;
            if (r_retry < RETRY_LIMIT) begin
              r_retry   <= r_retry + RW'(1);
              r_backoff <= '0;
              r_state   <= S_BACKOFF;
            end else begin
              r_status  <= TMN_TRY_AGAIN_LATER;
              r_cpu_ack <= 1'b1;
              r_state   <= S_DONE;
            end
          end else if (mst_ack) begin
            r_status  <= nub_tmn;
            r_cpu_ack <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_timer == TIMER_LAST) begin
            r_timeout <= 1'b1;
            r_status  <= TMN_TIMEOUT_ERROR;
            r_cpu_ack <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_BACKOFF: begin
          if (r_backoff == BACKOFF_LAST) begin
            r_timer <= '0;
            r_start <= 1'b1;
            r_state <= S_LAUNCH;
          end else begin
            r_backoff <= r_backoff + BW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack_o      = r_cpu_ack;
  assign cpu_status_o   = r_status;
  assign busy_o         = (r_state != S_IDLE);
  assign mst_start_o    = r_start;
  assign mst_timeout_o  = r_timeout;
  assign mst_tryagain_o = r_tryagain;

`ifdef NUBUS_RETRY_STATS_EN
  logic [7:0] r_stat;

  // Clear wins over a same-clock increment; the count sticks at 255.
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn || stat_clr) begin
      r_stat <= '0;
    end else if ((r_state == S_WAIT) && w_tal_ack && (r_stat != 8'hFF)) begin
      r_stat <= r_stat + 8'd1;
    end
  end

  assign stat_retries_o = r_stat;
`endif

endmodule

// File: tb/tb_nubus_master_retry.sv
// Bench for nubus_master_retry: directed scenarios plus random transactions against a transaction-level timeline model.
module tb_nubus_master_retry;

  localparam int T    = 255;
  localparam int RMAX = 7;
  localparam int BO   = 4;
  localparam int MAXC = 700;

  localparam logic [1:0] C_OK  = 2'd0;
  localparam logic [1:0] C_ERR = 2'd1;
  localparam logic [1:0] C_TMO = 2'd2;
  localparam logic [1:0] C_TAL = 2'd3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req = 1'b0;
  logic       ack = 1'b0;
  logic [1:0] tmn = 2'd0;
  logic       cpu_ack;
  logic [1:0] cpu_status;
  logic       busy;
  logic       mst_start;
  logic       mst_timeout;
  logic       mst_tryagain;
`ifdef NUBUS_RETRY_STATS_EN
  logic       stat_clr = 1'b0;
  logic [7:0] stat_retries;
  int         exp_stats = 0;
`endif

  nubus_master_retry #(
    .TIMEOUT_CYCLES(T),
    .RETRY_MAX(RMAX),
    .BACKOFF_CYCLES(BO)
  ) dut (
    .nub_clkn(clk),
    .nub_resetn(resetn),
    .cpu_req(req),
    .cpu_ack_o(cpu_ack),
    .cpu_status_o(cpu_status),
    .busy_o(busy),
    .mst_start_o(mst_start),
    .mst_ack(ack),
    .nub_tmn(tmn),
    .mst_timeout_o(mst_timeout),
    .mst_tryagain_o(mst_tryagain)
`ifdef NUBUS_RETRY_STATS_EN
    , .stat_clr(stat_clr), .stat_retries_o(stat_retries)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] prev_status = C_OK;

  // Attempt script: delay from start to ack (0 = never acks) and the code acked.
  int         att_d[8];
  logic [1:0] att_c[8];
  bit         clr_on_tal = 1'b0;

  bit         e_start[MAXC];
  bit         e_try[MAXC];
  bit         e_to[MAXC];
  bit         a_in[MAXC];
  bit         clr_in[MAXC];
  logic [1:0] t_in[MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_att(input int idx, input int d, input logic [1:0] c);
    att_d[idx] = d;
    att_c[idx] = c;
  endtask

  task automatic gen_random();
    for (int i = 0; i < 8; i++) begin
      int r;
      r = $urandom_range(99);
      att_d[i] = $urandom_range(8, 1);
      att_c[i] = C_OK;
      if (r < 55)      att_c[i] = C_TAL;
      else if (r < 75) att_c[i] = C_OK;
      else if (r < 85) att_c[i] = C_ERR;
      else if (r < 90) att_c[i] = C_TMO;
      else if (r < 95) att_d[i] = T - 1;
      else             att_d[i] = 0;
    end
  endtask

  // Builds the expected per-clock timeline from the attempt script, then drives and checks it.
  // Clock 0 is the request clock; expectations are for outputs seen after each edge.
  task automatic run_txn();
    int         s;
    int         a;
    int         done;
    int         retries;
    logic [1:0] st;
    bit         clr_done;
    for (int c = 0; c < MAXC; c++) begin
      e_start[c] = 1'b0;
      e_try[c]   = 1'b0;
      e_to[c]    = 1'b0;
      a_in[c]    = 1'b0;
      clr_in[c]  = 1'b0;
      t_in[c]    = 2'($urandom);
    end
    s = 1;
    retries = 0;
    done = 0;
    st = C_OK;
    clr_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e_start[s] = 1'b1;
      if (att_d[i] == 0) begin
        done = s + T;
        e_to[done] = 1'b1;
        st = C_TMO;
        break;
      end
      a = s + att_d[i];
      a_in[a] = 1'b1;
      t_in[a] = att_c[i];
      if (att_c[i] != C_TAL) begin
        done = a + 1;
        st = att_c[i];
        break;
      end
      e_try[a + 1] = 1'b1;
      if (clr_on_tal && !clr_done) begin
        clr_in[a] = 1'b1;
        clr_done = 1'b1;
      end
      if (retries == RMAX) begin
        done = a + 1;
        st = C_TAL;
        break;
      end
      retries++;
      if ($urandom_range(2) == 0) begin
        int k;
        k = a + 1 + $urandom_range(BO - 1);
        a_in[k] = 1'b1;
      end
      s = a + 1 + BO;
    end

    for (int c = 0; c <= done; c++) begin
      chk("start", mst_start, e_start[c]);
      chk("tryagain", mst_tryagain, e_try[c]);
      chk("timeout", mst_timeout, e_to[c]);
      chk("cpu_ack", cpu_ack, (c == done));
      chk("busy", busy, (c >= 1));
      chk("status", cpu_status, (c >= done) ? st : prev_status);
`ifdef NUBUS_RETRY_STATS_EN
      if (c > 0 && clr_in[c - 1]) exp_stats = 0;
      else if (e_try[c] && exp_stats < 255) exp_stats++;
      chk("stat_retries", stat_retries, exp_stats);
      stat_clr = clr_in[c];
`endif
      req = (c == 0) ? 1'b1 : ($urandom_range(7) == 0);
      ack = a_in[c];
      tmn = t_in[c];
      @(posedge clk);
      #1;
    end
    prev_status = st;
    req = 1'b0;
    ack = 1'b0;
`ifdef NUBUS_RETRY_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", cpu_ack, 1'b0);
    chk("rst_status", cpu_status, C_OK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", mst_start, 1'b0);
    chk("rst_timeout", mst_timeout, 1'b0);
    chk("rst_tryagain", mst_tryagain, 1'b0);
`ifdef NUBUS_RETRY_STATS_EN
    chk("rst_stats", stat_retries, 8'd0);
`endif
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single COMPLETE ack two clocks after the start.
    set_att(0, 2, C_OK);
    run_txn();
    // Two TRY_AGAIN_LATER acks then COMPLETE.
    set_att(0, 3, C_TAL); set_att(1, 1, C_TAL); set_att(2, 2, C_OK);
    run_txn();
    // Retry exhaustion.
    for (int i = 0; i < 8; i++) set_att(i, $urandom_range(5, 1), C_TAL);
    run_txn();
    // ERROR code passes through.
    set_att(0, 1, C_ERR);
    run_txn();
    // Slave-reported timeout: no timeout pulse.
    set_att(0, 4, C_TMO);
    run_txn();
    // Bus timeout with no ack, then ack exactly in the expiry clock.
    set_att(0, 0, C_OK);
    run_txn();
    set_att(0, T - 1, C_OK);
    run_txn();

    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_txn();
    end

    // Reset in the middle of WAIT aborts without an ack.
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rw_start", mst_start, 1'b1);
    @(posedge clk); #1;
    chk("rw_busy_wait", busy, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    prev_status = C_OK;
    chk("rw_busy", busy, 1'b0);
    chk("rw_ack", cpu_ack, 1'b0);
    chk("rw_status", cpu_status, C_OK);
`ifdef NUBUS_RETRY_STATS_EN
    exp_stats = 0;
    chk("rw_stats", stat_retries, 8'd0);
`endif
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("rw_no_ack", cpu_ack, 1'b0);
      chk("rw_no_start", mst_start, 1'b0);
    end
    set_att(0, 2, C_OK);
    run_txn();

`ifdef NUBUS_RETRY_STATS_EN
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    exp_stats = 0;
    prev_status = C_OK;
    for (int r = 0; r < 2; r++) begin
      set_att(0, 3, C_TAL); set_att(1, 1, C_TAL); set_att(2, 2, C_OK);
      run_txn();
    end
    chk("stats_four", stat_retries, 8'd4);
    clr_on_tal = 1'b1;
    set_att(0, 2, C_TAL); set_att(1, 2, C_OK);
    run_txn();
    clr_on_tal = 1'b0;
    chk("stats_clr", stat_retries, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
